// File: rtl/conv_encoder_sys_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder_sys_if
// Purpose  : Bundles the word-input handshake, the K select and the symbol
//            output handshake of conv_encoder_sys.
// Modports : master - data source / symbol sink side (drives data_in,
//                     data_valid, choose_constraint_length, sym_ready)
//            slave  - encoder side (drives data_ready, encoded_bits,
//                     sym_valid, sym_first, sym_last, busy)
// Revision : 1.0 - initial release
// ============================================================================
interface conv_encoder_sys_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic [2:0]        choose_constraint_length;
  logic [1:0]        encoded_bits;
  logic              sym_valid;
  logic              sym_ready;
  logic              sym_first;
  logic              sym_last;
  logic              busy;

  modport master (
    output data_in, data_valid, choose_constraint_length, sym_ready,
    input  data_ready, encoded_bits, sym_valid, sym_first, sym_last, busy
  );

  modport slave (
    input  data_in, data_valid, choose_constraint_length, sym_ready,
    output data_ready, encoded_bits, sym_valid, sym_first, sym_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/conv_encoder_sys.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder_sys
// Purpose  : Rate-1/2 zero-terminated convolutional encoder. Accepts one
//            DATA_W-bit word, serialises it MSB first, emits one 2-bit symbol
//            per bit followed by K-1 zero-input tail symbols so the decoder
//            trellis ends in state 0. K (3..6) is latched per frame.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous reset, active high
//            bus  - conv_encoder_sys_if.slave: word handshake
//                   (data_in/data_valid/data_ready), K select, symbol
//                   handshake (encoded_bits/sym_valid/sym_ready) with
//                   sym_first/sym_last framing, and busy
// Revision : 1.0 - initial release
// ============================================================================
module conv_encoder_sys #(
  parameter int DATA_W = 16,
  parameter int MAX_K  = 6
) (
  input  wire logic          clk,
  input  wire logic          rst,
  conv_encoder_sys_if.slave  bus
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_DATA = 2'd1;
  localparam logic [1:0] c_ST_TAIL = 2'd2;

  // Index of the last data symbol; the tail starts after it is accepted.
  localparam logic [4:0] c_LAST_DATA_IDX = 5'(DATA_W - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  // r_word[DATA_W-1] is always the input bit u of the symbol on the bus;
  // shifting left with zero fill makes the tail bits fall out naturally.
  logic [DATA_W-1:0] r_word;
  // r_mem[MAX_K-2] is m1 (most recent bit), r_mem[0] the oldest.
  logic [MAX_K-2:0]  r_mem;
  logic [2:0]        r_k;
  logic [4:0]        r_cnt;
  logic [1:0]        r_bits;
  logic              r_sym_valid;
  logic              r_first;
  logic              r_last;

  logic              w_data_ready;
  logic              w_busy;
  logic              w_accept_in;
  logic              w_accept_sym;
  logic [2:0]        w_k_sel;
  logic [4:0]        w_last_idx;
  logic [4:0]        w_cnt_nxt;
  logic              w_is_last;
  logic              w_data_done;
  logic [MAX_K-2:0]  w_mem_nxt;
  logic [DATA_W-1:0] w_word_nxt;

  // Symbol for input u and memory mem under constraint length k.
  // The register vector {u, m1..m(MAX_K-1)} is right-aligned to K bits, which
  // discards memory stages beyond K-1 so generators can be used as written.
  function automatic logic [1:0] f_symbol(
    input logic             u,
    input logic [MAX_K-2:0] mem,
    input logic [2:0]       k
  );
    logic [MAX_K-1:0] w_full;
    logic [MAX_K-1:0] w_reg;
    logic [MAX_K-1:0] w_g0;
    logic [MAX_K-1:0] w_g1;
    w_full = {u, mem};
    w_reg  = w_full >> (MAX_K - int'(k));
    case (k)
      3'd4:    begin w_g0 = MAX_K'(6'o15); w_g1 = MAX_K'(6'o17); end
      3'd5:    begin w_g0 = MAX_K'(6'o23); w_g1 = MAX_K'(6'o35); end
      3'd6:    begin w_g0 = MAX_K'(6'o53); w_g1 = MAX_K'(6'o75); end
      default: begin w_g0 = MAX_K'(6'o07); w_g1 = MAX_K'(6'o05); end
    endcase
    return {^(w_reg & w_g0), ^(w_reg & w_g1)};
  endfunction

  // Out-of-range K selects fall back to K=3.
  assign w_k_sel = ((bus.choose_constraint_length >= 3'd3) &&
                    (bus.choose_constraint_length <= 3'd6))
                   ? bus.choose_constraint_length : 3'd3;

  assign w_accept_in  = bus.data_valid & w_data_ready;
  assign w_accept_sym = r_sym_valid & bus.sym_ready;

  // Frame has DATA_W + K - 1 symbols, so the last index is DATA_W + K - 2.
  assign w_last_idx  = 5'(DATA_W - 2) + {2'b00, r_k};
  assign w_cnt_nxt   = r_cnt + 5'd1;
  assign w_is_last   = (r_cnt == w_last_idx);
  assign w_data_done = (r_cnt == c_LAST_DATA_IDX);
  assign w_mem_nxt   = {r_word[DATA_W-1], r_mem[MAX_K-2:1]};
  assign w_word_nxt  = {r_word[DATA_W-2:0], 1'b0};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept_in)                 w_state_nxt = c_ST_DATA;
      c_ST_DATA: if (w_accept_sym && w_data_done) w_state_nxt = c_ST_TAIL;
      c_ST_TAIL: if (w_accept_sym && w_is_last)   w_state_nxt = c_ST_IDLE;
      default:                                    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State-decoded outputs; data_ready is held low during reset.
  always_comb begin
    w_data_ready = 1'b0;
    w_busy       = 1'b1;
    if (r_state == c_ST_IDLE) begin
      w_data_ready = ~rst;
      w_busy       = 1'b0;
    end
  end

  // Symbol datapath: symbols are computed one step ahead and held in
  // registers, so the outputs stay stable for as long as sym_ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word      <= '0;
      r_mem       <= '0;
      r_k         <= 3'd3;
      r_cnt       <= 5'd0;
      r_bits      <= 2'b00;
      r_sym_valid <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_accept_in) begin
      r_word      <= bus.data_in;
      r_k         <= w_k_sel;
      r_mem       <= '0;
      r_cnt       <= 5'd0;
      r_bits      <= f_symbol(bus.data_in[DATA_W-1], '0, w_k_sel);
      r_sym_valid <= 1'b1;
      r_first     <= 1'b1;
      r_last      <= 1'b0;
    end else if (w_accept_sym) begin
      if (w_is_last) begin
        r_word      <= '0;
        r_mem       <= '0;
        r_cnt       <= 5'd0;
        r_bits      <= 2'b00;
        r_sym_valid <= 1'b0;
        r_first     <= 1'b0;
        r_last      <= 1'b0;
      end else begin
        r_word  <= w_word_nxt;
        r_mem   <= w_mem_nxt;
        r_cnt   <= w_cnt_nxt;
        r_bits  <= f_symbol(w_word_nxt[DATA_W-1], w_mem_nxt, r_k);
        r_first <= 1'b0;
        r_last  <= (w_cnt_nxt == w_last_idx);
      end
    end
  end

  assign bus.data_ready   = w_data_ready;
  assign bus.busy         = w_busy;
  assign bus.encoded_bits = r_bits;
  assign bus.sym_valid    = r_sym_valid;
  assign bus.sym_first    = r_first;
  assign bus.sym_last     = r_last;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_sys.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_encoder_sys
// Purpose  : Self-checking bench for conv_encoder_sys. Expected symbol
//            streams come from directed constant sequences or from a
//            bit-level reference model of the encoder (sliding window over
//            the message bits plus zero tail, parity of window & generator).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_encoder_sys;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv_encoder_sys_if #(.DATA_W(16)) u_if ();

  conv_encoder_sys #(
    .DATA_W (16),
    .MAX_K  (6)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Entry: [3:2] encoded bits, [1] first flag, [0] last flag
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: symbol i uses window {b[i], b[i-1], .., b[i-K+1]} with
  // b[i] the MSB, over message bits (MSB of word first) followed by K-1 zeros.
  task automatic model_frame(input logic [15:0] word, input int kin);
    int k;
    int g0;
    int g1;
    int n;
    int b[0:20];
    int r;
    int bt;
    k = (kin >= 3 && kin <= 6) ? kin : 3;
    case (k)
      4:       begin g0 = 'o15; g1 = 'o17; end
      5:       begin g0 = 'o23; g1 = 'o35; end
      6:       begin g0 = 'o53; g1 = 'o75; end
      default: begin g0 = 'o7;  g1 = 'o5;  end
    endcase
    n = 16 + k - 1;
    for (int i = 0; i < 21; i++) b[i] = (i < 16) ? int'(word[15-i]) : 0;
    for (int i = 0; i < n; i++) begin
      r = 0;
      for (int j = 0; j < k; j++) begin
        bt = (i - j >= 0) ? b[i-j] : 0;
        r = r * 2 + bt;
      end
      exp_q.push_back({1'($countones(r & g0) % 2), 1'($countones(r & g1) % 2),
                       1'(i == 0), 1'(i == n - 1)});
    end
  endtask

  task automatic push_sym(input logic [1:0] s, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back({s, 2'b00});
  endtask

  task automatic mark_frame();
    exp_q[0][1] = 1'b1;
    exp_q[exp_q.size()-1][0] = 1'b1;
  endtask

  task automatic const_8000();
    push_sym(2'b11, 1); push_sym(2'b10, 1); push_sym(2'b11, 1); push_sym(2'b00, 15);
    mark_frame();
  endtask

  task automatic const_ffff();
    push_sym(2'b11, 1); push_sym(2'b01, 1); push_sym(2'b10, 14);
    push_sym(2'b01, 1); push_sym(2'b11, 1);
    mark_frame();
  endtask

  // Sends one word and consumes the frame, checking every presented symbol
  // against the head of exp_q (so stalled cycles also check stability).
  task automatic run_frame(input logic [15:0] word, input logic [2:0] kin,
                           input int stall_at, input int abort_after,
                           input bit inject, input bit rand_ready);
    int idx   = 0;
    int cyc   = 0;
    int stall = 0;
    int total = exp_q.size();
    @(negedge clk);
    check("idle_state", {29'd0, u_if.data_ready, u_if.busy, u_if.sym_valid}, 32'b100);
    u_if.data_in                  = word;
    u_if.choose_constraint_length = kin;
    u_if.data_valid               = 1'b1;
    u_if.sym_ready                = 1'b0;
    @(posedge clk);
    #1;
    u_if.data_valid               = 1'b0;
    u_if.data_in                  = 16'($urandom);
    u_if.choose_constraint_length = 3'($urandom_range(0, 7));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      u_if.data_valid = 1'b0;
      if (cyc > 400) begin
        check("frame_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        break;
      end
      if (abort_after >= 0 && idx == abort_after) begin
        rst = 1'b1;
        #1;
        check("abort_outputs", {25'd0, u_if.sym_valid, u_if.busy, u_if.data_ready,
                                u_if.encoded_bits, u_if.sym_first, u_if.sym_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        u_if.sym_ready = 1'b0;
        exp_q.delete();
        return;
      end
      check("symbol", {27'd0, u_if.sym_valid, u_if.encoded_bits, u_if.sym_first, u_if.sym_last},
            {27'd0, 1'b1, exp_q[0]});
      check("busy_ready", {30'd0, u_if.busy, u_if.data_ready}, 32'b10);
      if (inject && idx == 3) begin
        u_if.data_valid = 1'b1;
        u_if.data_in    = 16'h1234;
      end
      if (idx == stall_at && stall < 3) begin
        u_if.sym_ready = 1'b0;
        stall++;
      end else if (rand_ready) begin
        u_if.sym_ready = ($urandom_range(0, 3) != 0);
      end else begin
        u_if.sym_ready = 1'b1;
      end
      if (u_if.sym_ready) begin
        void'(exp_q.pop_front());
        idx++;
      end
    end
    @(negedge clk);
    u_if.sym_ready  = 1'b0;
    u_if.data_valid = 1'b0;
    check("symbol_count", 32'(idx), 32'(total));
    check("end_idle", {29'd0, u_if.sym_valid, u_if.busy, u_if.data_ready}, 32'b001);
  endtask

  initial begin
    logic [15:0] w;
    logic [2:0]  k;
    rst                           = 1'b1;
    u_if.data_in                  = 16'h0;
    u_if.data_valid               = 1'b0;
    u_if.choose_constraint_length = 3'd3;
    u_if.sym_ready                = 1'b0;

    // Reset state, with data_valid asserted to show it is not taken in reset
    #2;
    u_if.data_valid = 1'b1;
    @(negedge clk);
    check("reset_outputs", {25'd0, u_if.sym_valid, u_if.busy, u_if.data_ready,
                            u_if.encoded_bits, u_if.sym_first, u_if.sym_last}, 32'd0);
    u_if.data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed frames
    const_8000(); run_frame(16'h8000, 3'd3, -1, -1, 1'b0, 1'b0);
    const_ffff(); run_frame(16'hFFFF, 3'd3, -1, -1, 1'b0, 1'b0);
    const_8000(); run_frame(16'h8000, 3'd7, -1, -1, 1'b0, 1'b0);

    // K=6, stall at symbol #5 for three cycles
    w = 16'($urandom);
    model_frame(w, 6); run_frame(w, 3'd6, 4, -1, 1'b0, 1'b0);

    // Abort after five symbols, then a clean 16'h8000 frame
    w = 16'($urandom);
    model_frame(w, 4); run_frame(w, 3'd4, -1, 5, 1'b0, 1'b0);
    const_8000(); run_frame(16'h8000, 3'd3, -1, -1, 1'b0, 1'b0);

    // Mid-frame data_valid with 16'h1234 is ignored
    w = 16'($urandom);
    model_frame(w, 5); run_frame(w, 3'd5, -1, -1, 1'b1, 1'b0);

    // Randomized frames with random backpressure and K selects 0..7
    for (int f = 0; f < 40; f++) begin
      w = 16'($urandom);
      k = 3'($urandom_range(0, 7));
      model_frame(w, int'(k));
      run_frame(w, k, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1,
                -1, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
